// File: rtl/ahb_decode_resp_s4_pkg.sv
// ahb_dec_pkg: shared encodings for the 4-slave AHB decoder and response mux
package ahb_dec_pkg;
    typedef enum logic [1:0] {HT_IDLE = 2'd0, HT_BUSY = 2'd1, HT_NONSEQ = 2'd2, HT_SEQ = 2'd3} htrans_t;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [2:0] {
        DSEL_S0   = 3'd0,
        DSEL_S1   = 3'd1,
        DSEL_S2   = 3'd2,
        DSEL_S3   = 3'd3,
        DSEL_DEF  = 3'd4,
        DSEL_NONE = 3'd5
    } dsel_t;
    typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_t;
endpackage

// File: rtl/ahb_decode_resp_s4_if.sv
// ahb_decode_resp_s4_if: master-side and slave-side signals of the 4-slave decoder
interface ahb_decode_resp_s4_if;
    logic [31:0] HADDRm;
    logic [1:0]  HTRANSm;
    logic        SEL0, SEL1, SEL2, SEL3;
    logic [31:0] HRDATAS0, HRDATAS1, HRDATAS2, HRDATAS3;
    logic        HREADYOUTS0, HREADYOUTS1, HREADYOUTS2, HREADYOUTS3;
    logic        HRESPS0, HRESPS1, HRESPS2, HRESPS3;
    logic [31:0] HRDATAm;
    logic        HREADYm, HRESPm;
    modport slave (
        input  HADDRm, HTRANSm,
        input  HRDATAS0, HRDATAS1, HRDATAS2, HRDATAS3,
        input  HREADYOUTS0, HREADYOUTS1, HREADYOUTS2, HREADYOUTS3,
        input  HRESPS0, HRESPS1, HRESPS2, HRESPS3,
        output SEL0, SEL1, SEL2, SEL3,
        output HRDATAm, HREADYm, HRESPm
    );
    modport master (
        output HADDRm, HTRANSm,
        output HRDATAS0, HRDATAS1, HRDATAS2, HRDATAS3,
        output HREADYOUTS0, HREADYOUTS1, HREADYOUTS2, HREADYOUTS3,
        output HRESPS0, HRESPS1, HRESPS2, HRESPS3,
        input  SEL0, SEL1, SEL2, SEL3,
        input  HRDATAm, HREADYm, HRESPm
    );
endinterface

// File: rtl/ahb_decode_resp_s4_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped transfers.
// With AHB_DEC_TIMEOUT_EN it also aborts a slave stalled for TIMEOUT_CYC cycles.
module ahb_default_slave
    import ahb_dec_pkg::*;
`ifdef AHB_DEC_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef AHB_DEC_TIMEOUT_EN
    input  logic stall,
`endif
    output logic ready,
    output logic resp
);
    ds_state_t state;
    logic      go;
`ifdef AHB_DEC_TIMEOUT_EN
    logic [7:0] cnt;
    logic       tmo;
    assign tmo = stall && state == DS_IDLE && cnt + 8'd1 == 8'(TIMEOUT_CYC);
    always_ff @(posedge clk)
        cnt <= (rst || !stall || tmo) ? '0 : cnt + 8'd1;
    assign go = start | tmo;
`else
    assign go = start;
`endif
    // resp doubles as "responder owns the bus" for the top-level mux
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DS_IDLE;
            ready <= 1'b1;
            resp  <= HRESP_OKAY;
        end else if (state == DS_ERR1) begin
            state <= DS_ERR2;
            ready <= 1'b1;
            resp  <= HRESP_ERROR;
        end else if (go) begin
            state <= DS_ERR1;
            ready <= 1'b0;
            resp  <= HRESP_ERROR;
        end else begin
            state <= DS_IDLE;
            ready <= 1'b1;
            resp  <= HRESP_OKAY;
        end
    end
endmodule

// File: rtl/ahb_decode_resp_s4.sv
// ahb_decode_resp_s4: 4-slave AHB address decoder and response multiplexer.
// Optional slave-stall timeout enabled by AHB_DEC_TIMEOUT_EN.
module ahb_decode_resp_s4
    import ahb_dec_pkg::*;
#(
    parameter logic [31:0] S0_BASE     = 32'h0000_0000,
    parameter logic [31:0] S1_BASE     = 32'h1000_0000,
    parameter logic [31:0] S2_BASE     = 32'h2000_0000,
    parameter logic [31:0] S3_BASE     = 32'h3000_0000,
    parameter logic [31:0] REGION_MASK = 32'hF000_0000
`ifdef AHB_DEC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic HCLK,
    input  logic HRESET,
    ahb_decode_resp_s4_if.slave bus
);
    logic [3:0]  hit, sel, rdy, rsp;
    logic [31:0] rd [4];
    logic        active, d_ready, d_resp;
    dsel_t       dsel, dsel_n;
    assign active = bus.HTRANSm[1] & ~HRESET;
    assign hit = {(bus.HADDRm & REGION_MASK) == (S3_BASE & REGION_MASK),
                  (bus.HADDRm & REGION_MASK) == (S2_BASE & REGION_MASK),
                  (bus.HADDRm & REGION_MASK) == (S1_BASE & REGION_MASK),
                  (bus.HADDRm & REGION_MASK) == (S0_BASE & REGION_MASK)};
    // lowest set bit wins, giving S0 > S1 > S2 > S3 on overlapping regions
    assign sel = active ? hit & ~(hit - 4'd1) : 4'd0;
    assign {bus.SEL3, bus.SEL2, bus.SEL1, bus.SEL0} = sel;
    always_comb
        dsel_n = !active ? DSEL_NONE :
                 sel[0]  ? DSEL_S0 :
                 sel[1]  ? DSEL_S1 :
                 sel[2]  ? DSEL_S2 :
                 sel[3]  ? DSEL_S3 : DSEL_DEF;
    always_ff @(posedge HCLK) begin
        if (HRESET)
            dsel <= DSEL_NONE;
        else if (bus.HREADYm)
            dsel <= dsel_n;
    end
    assign rd  = '{bus.HRDATAS0, bus.HRDATAS1, bus.HRDATAS2, bus.HRDATAS3};
    assign rdy = {bus.HREADYOUTS3, bus.HREADYOUTS2, bus.HREADYOUTS1, bus.HREADYOUTS0};
    assign rsp = {bus.HRESPS3, bus.HRESPS2, bus.HRESPS1, bus.HRESPS0};
    // an erroring default slave overrides any slave dsel may still point at
    always_comb begin
        bus.HRDATAm = '0;
        bus.HREADYm = 1'b1;
        bus.HRESPm  = HRESP_OKAY;
        if (!HRESET && d_resp) begin
            bus.HREADYm = d_ready;
            bus.HRESPm  = d_resp;
        end else if (!HRESET && !dsel[2]) begin
            bus.HRDATAm = rd[dsel[1:0]];
            bus.HREADYm = rdy[dsel[1:0]];
            bus.HRESPm  = rsp[dsel[1:0]];
        end
    end
    ahb_default_slave
`ifdef AHB_DEC_TIMEOUT_EN
        #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_def (
        .clk   (HCLK),
        .rst   (HRESET),
        .start (dsel_n == DSEL_DEF && bus.HREADYm),
`ifdef AHB_DEC_TIMEOUT_EN
        .stall (!dsel[2] && !bus.HREADYm),
`endif
        .ready (d_ready),
        .resp  (d_resp)
    );
endmodule

// File: doc/ahb_decode_resp_s4.md
Name: ahb_decode_resp_s4

Overview:
Address decoder and slave-to-master response multiplexer for the 4-slave AHB fabric. It decodes HADDRm into one-hot SEL0..SEL3, which drive the master-to-slave data/address fanout mux. It registers the selection into the data phase and routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master. An internal default slave returns a two-cycle ERROR response for unmapped transfers.

Parameters:
S0_BASE, 32'h0000_0000, region base for slave 0
S1_BASE, 32'h1000_0000, region base for slave 1
S2_BASE, 32'h2000_0000, region base for slave 2
S3_BASE, 32'h3000_0000, region base for slave 3
REGION_MASK, 32'hF000_0000, address bits compared against each base
TIMEOUT_CYC, 16, wait-state limit; used only with AHB_DEC_TIMEOUT_EN; legal range 2..255

Ports:
HCLK  in  1  system clock
HRESET  in  1  synchronous reset, active-high
HADDRm  in  32  master address
HTRANSm  in  2  master transfer type
SEL0..SEL3  out  1 each  one-hot address-phase slave select (combinational)
HRDATAS0..HRDATAS3  in  32 each  slave read data
HREADYOUTS0..HREADYOUTS3  in  1 each  slave ready
HRESPS0..HRESPS3  in  1 each  slave response (0=OKAY, 1=ERROR)
HRDATAm  out  32  read data to master
HREADYm  out  1  system HREADY; to master and to mux HREADYINm
HRESPm  out  1  response to master

Behaviour:
- Active transfer: HTRANSm[1]==1 (NONSEQ/SEQ).
- Address-phase decode is combinational. SELx=1 iff active and (HADDRm & REGION_MASK)==(Sx_BASE & REGION_MASK).
  - Overlap priority: S0>S1>S2>S3. At most one SEL is high.
  - Active with no match: all SEL=0 and the transfer targets the default slave.
  - IDLE/BUSY: all SEL=0.
- Data-phase register dsel (3 bits): S0=0..S3=3, DEF=4, NONE=5.
  - Loads on each HCLK edge where HREADYm==1: slave index, DEF for unmapped active, NONE for IDLE/BUSY.
  - Holds while HREADYm==0.
- Response mux, selected by dsel:
  - 0..3: HRDATAm/HREADYm/HRESPm = HRDATASx/HREADYOUTSx/HRESPSx.
  - NONE: HRDATAm=0, HREADYm=1, HRESPm=0.
  - DEF: HRDATAm=0; HREADYm/HRESPm from the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE->ERR1 when an unmapped active transfer is accepted (HREADYm==1). ERR1 output: HREADYm=0, HRESPm=1.
  - ERR1->ERR2 unconditionally. ERR2 output: HREADYm=1, HRESPm=1.
  - ERR2->ERR1 if another unmapped active transfer is accepted in that cycle; otherwise ERR2->IDLE.
- Latency: decode 0 cycles. Response routed in the cycle after address acceptance. No added wait states for mapped slaves.
- Reset values: HRDATAm=0, HREADYm=1, HRESPm=0, dsel=NONE, FSM=IDLE. SELx follow inputs but are forced 0 while HRESET=1.
- Reset asserted mid-transfer (including during ERR1, or while a slave stalls) abandons the response. The next cycle shows reset values.
- A slave's HRESP=1 with HREADYOUT=0 is passed through unchanged; the block does not enforce slave protocol.

Optional Feature:
AHB_DEC_TIMEOUT_EN
- Defined:
  - An 8-bit counter counts consecutive cycles with dsel in 0..3 and HREADYm==0.
  - When the count reaches TIMEOUT_CYC, the block overrides the slave with the default-slave ERR1/ERR2 sequence and reloads dsel on ERR2.
  - The counter clears on HREADYm==1 or reset.
  - The stalled slave's late HREADYOUT is ignored after the override.
- Undefined: no counter; the block waits indefinitely on a stalled slave.

Decomposition:
- Package ahb_dec_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP OKAY/ERROR, dsel constants (DSEL_S0..DSEL_S3, DSEL_DEF, DSEL_NONE), FSM state encoding.
- Sub-module ahb_default_slave: IDLE/ERR1/ERR2 FSM, plus the timeout counter when AHB_DEC_TIMEOUT_EN is defined.

Test Plan:
- NONSEQ HADDRm=32'h2000_0040 -> SEL2=1 same cycle. Next cycle HRDATAm=HRDATAS2 (drive 32'hCAFE_F00D), HRESPm=0.
- NONSEQ to 32'h1000_0000 with HREADYOUTS1 low 3 cycles -> HREADYm low 3 cycles, dsel held at 1, HRDATAm valid on the 4th cycle.
- NONSEQ to unmapped 32'h8000_0000 -> all SEL=0. Next cycle HREADYm=0/HRESPm=1, then HREADYm=1/HRESPm=1, then OKAY.
- Back-to-back unmapped NONSEQ issued in the ERR2 cycle -> FSM ERR2->ERR1; two complete error pairs with no OKAY gap.
- HRESET=1 during ERR1 -> next cycle HREADYm=1, HRESPm=0, HRDATAm=0. A subsequent mapped access to S0 completes normally.
- AHB_DEC_TIMEOUT_EN, TIMEOUT_CYC=16, HREADYOUTS3 held 0 -> 16 wait cycles, then ERROR pair. Without the macro, HREADYm stays 0 for 100 cycles.
